// File: rtl/store_queue_mc.sv
// Multi-commit store queue: in-order allocate, out-of-order write-back, up to COMMIT_WIDTH_P
// commits per cycle, single-port drain to memory, store-to-load forwarding and squash on flush.
module store_queue_mc #(
  parameter int WORD_SIZE_P    = 16,
  parameter int SB_ENTRY_P     = 8,
  parameter int COMMIT_WIDTH_P = 2,
  localparam int IW = $clog2(SB_ENTRY_P),
  localparam int CW = $clog2(COMMIT_WIDTH_P + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   alloc_v_i,
  output logic                   alloc_ready_o,
  output logic [IW-1:0]          alloc_entry_o,
  input  logic                   wb_v_i,
  input  logic [IW-1:0]          wb_entry_i,
  input  logic [WORD_SIZE_P-1:0] wb_addr_i,
  input  logic [WORD_SIZE_P-1:0] wb_data_i,
  input  logic [CW-1:0]          commit_cnt_i,
  input  logic                   flush_i,
  input  logic [WORD_SIZE_P-1:0] ld_addr_i,
  input  logic [IW-1:0]          ld_sb_num_i,
  output logic                   ld_fwd_v_o,
  output logic [WORD_SIZE_P-1:0] ld_fwd_data_o,
  output logic                   ld_replay_o,
  output logic                   mem_v_o,
  output logic [WORD_SIZE_P-1:0] mem_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_data_o,
  input  logic                   mem_ready_i,
  output logic                   clear_v_o,
  output logic [IW-1:0]          clear_num_o,
  output logic [SB_ENTRY_P-1:0]  wb_vector_o,
  output logic [IW-1:0]          commit_pt_o,
  output logic                   empty_o
);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_WB    = 2'd2,
    ST_CMT   = 2'd3
  } entry_state_e;

  logic [IW:0]            head_r, commit_r, tail_r;
  entry_state_e           state_r     [SB_ENTRY_P];
  entry_state_e           state_nxt_s [SB_ENTRY_P];
  logic [WORD_SIZE_P-1:0] addr_r      [SB_ENTRY_P];
  logic [WORD_SIZE_P-1:0] data_r      [SB_ENTRY_P];
  logic [IW-1:0]          scan_idx_s  [SB_ENTRY_P];

  logic [IW-1:0]         head_idx_s, tail_idx_s;
  logic                  full_s, alloc_fire_s, mem_v_s, drain_fire_s;
  logic [IW:0]           commit_nxt_s, squash_cnt_s, scan_len_s, live_len_s;
  logic [SB_ENTRY_P-1:0] covered_s, squash_s, wb_hit_s, wb_now_s;
  logic                  fwd_hit_s, fwd_pend_s;
  logic [WORD_SIZE_P-1:0] fwd_data_s;
  logic                  wb_bad_s, commit_bad_s;

  // Ring distance from b forward to a, widened so it compares against full pointer counts.
  function automatic logic [IW:0] ring_off(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW-1:0] d;
    d = a - b;
    return {1'b0, d};
  endfunction

  assign head_idx_s = head_r[IW-1:0];
  assign tail_idx_s = tail_r[IW-1:0];

  // Pointer-derived status and handshakes; alloc_ready depends only on registered pointers.
  always_comb begin
    full_s        = (head_idx_s == tail_idx_s) && (head_r[IW] != tail_r[IW]);
    empty_o       = (head_r == tail_r);
    alloc_ready_o = ~full_s;
    alloc_fire_s  = alloc_v_i & ~full_s & ~flush_i;
    mem_v_s       = (head_r != commit_r) && (state_r[head_idx_s] == ST_CMT);
    drain_fire_s  = mem_v_s & mem_ready_i;
    commit_nxt_s  = commit_r + (IW+1)'(commit_cnt_i);
    squash_cnt_s  = tail_r - commit_nxt_s;
    alloc_entry_o = tail_idx_s;
    commit_pt_o   = commit_r[IW-1:0];
    mem_v_o       = mem_v_s;
    mem_addr_o    = mem_v_s ? addr_r[head_idx_s] : {WORD_SIZE_P{1'b0}};
    mem_data_o    = mem_v_s ? data_r[head_idx_s] : {WORD_SIZE_P{1'b0}};
    clear_v_o     = drain_fire_s;
    clear_num_o   = head_idx_s;
  end

  // Per-entry next state: squash beats drain/alloc, commit beats a same-cycle write-back.
  always_comb begin
    for (int i = 0; i < SB_ENTRY_P; i++) begin
      covered_s[i] = ring_off(IW'(i), commit_r[IW-1:0]) < (IW+1)'(commit_cnt_i);
      squash_s[i]  = flush_i && (ring_off(IW'(i), commit_nxt_s[IW-1:0]) < squash_cnt_s);
      wb_now_s[i]  = (state_r[i] == ST_WB);
      wb_hit_s[i]  = wb_v_i && (wb_entry_i == IW'(i)) && !squash_s[i] &&
                     ((state_r[i] == ST_ALLOC) || (state_r[i] == ST_WB));
      wb_vector_o[i] = (state_r[i] == ST_WB) || (state_r[i] == ST_CMT);
      if (squash_s[i]) begin
        state_nxt_s[i] = ST_FREE;
      end else if (drain_fire_s && (head_idx_s == IW'(i))) begin
        state_nxt_s[i] = ST_FREE;
      end else if (alloc_fire_s && (tail_idx_s == IW'(i))) begin
        state_nxt_s[i] = ST_ALLOC;
      end else if (covered_s[i]) begin
        state_nxt_s[i] = ST_CMT;
      end else if (wb_hit_s[i]) begin
        state_nxt_s[i] = ST_WB;
      end else begin
        state_nxt_s[i] = state_r[i];
      end
    end
  end

  // Forwarding scan from oldest to youngest: a later match clears any older pending ALLOC.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_pend_s = 1'b0;
    fwd_data_s = {WORD_SIZE_P{1'b0}};
    scan_len_s = ring_off(ld_sb_num_i, head_idx_s);
    live_len_s = tail_r - head_r;
    for (int k = 0; k < SB_ENTRY_P; k++) begin
      scan_idx_s[k] = head_idx_s + IW'(k);
      if (((IW+1)'(k) < scan_len_s) && ((IW+1)'(k) < live_len_s)) begin
        if (((state_r[scan_idx_s[k]] == ST_WB) || (state_r[scan_idx_s[k]] == ST_CMT)) &&
            (addr_r[scan_idx_s[k]] == ld_addr_i)) begin
          fwd_hit_s  = 1'b1;
          fwd_pend_s = 1'b0;
          fwd_data_s = data_r[scan_idx_s[k]];
        end else if (state_r[scan_idx_s[k]] == ST_ALLOC) begin
          fwd_pend_s = 1'b1;
        end else begin
          fwd_pend_s = fwd_pend_s;
        end
      end else begin
        fwd_pend_s = fwd_pend_s;
      end
    end
    ld_fwd_v_o    = fwd_hit_s & ~fwd_pend_s;
    ld_replay_o   = fwd_pend_s;
    ld_fwd_data_o = (fwd_hit_s & ~fwd_pend_s) ? fwd_data_s : {WORD_SIZE_P{1'b0}};
  end

  // Protocol-violation flags consumed by the checker.
  always_comb begin
    wb_bad_s     = wb_v_i && ((state_r[wb_entry_i] == ST_FREE) || (state_r[wb_entry_i] == ST_CMT));
    commit_bad_s = ((IW+1)'(commit_cnt_i) > (tail_r - commit_r)) || |(covered_s & ~wb_now_s);
  end

  // Queue state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r   <= {(IW+1){1'b0}};
      commit_r <= {(IW+1){1'b0}};
      tail_r   <= {(IW+1){1'b0}};
      for (int i = 0; i < SB_ENTRY_P; i++) begin
        state_r[i] <= ST_FREE;
        addr_r[i]  <= {WORD_SIZE_P{1'b0}};
        data_r[i]  <= {WORD_SIZE_P{1'b0}};
      end
    end else begin
      head_r   <= head_r + (IW+1)'(drain_fire_s);
      commit_r <= commit_nxt_s;
      tail_r   <= flush_i ? commit_nxt_s : tail_r + (IW+1)'(alloc_fire_s);
      for (int i = 0; i < SB_ENTRY_P; i++) begin
        state_r[i] <= state_nxt_s[i];
        if (wb_hit_s[i]) begin
          addr_r[i] <= wb_addr_i;
          data_r[i] <= wb_data_i;
        end
      end
    end
  end

  store_queue_mc_chk u_chk (
    .clk        (clk_i),
    .rst        (reset_i),
    .wb_bad     (wb_bad_s),
    .commit_bad (commit_bad_s)
  );

endmodule

// Protocol checks on the store queue's write-back and commit inputs.
module store_queue_mc_chk (
  input logic clk,
  input logic rst,
  input logic wb_bad,
  input logic commit_bad
);

  a_wb_legal: assert property (@(posedge clk) disable iff (rst) !wb_bad)
    else $error("store_queue_mc: write-back to a free or committed entry");

  a_commit_legal: assert property (@(posedge clk) disable iff (rst) !commit_bad)
    else $error("store_queue_mc: commit covers an entry not written back or beyond tail");

endmodule
